// File: rtl/projectile_ctl.sv
// Player projectile controller: launches on a fire press, climbs one
// step per frame tick, retires on hit or screen top, then cools down.
module projectile_ctl #(
  parameter int PLAYER_WIDTH     = 64,
  parameter int PROJECTILE_WIDTH = 16,
  parameter int LAUNCH_Y         = 668,
  parameter int SPEED            = 8,
  parameter int COOLDOWN_FRAMES  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        fire,
  input  logic        game_active,
  input  logic [11:0] player_xpos,
  input  logic        bullet_hit,
  output logic [11:0] projectile_xpos,
  output logic [11:0] projectile_ypos,
  output logic        bullet_active,
  output logic        shot_fired
);

  localparam int CW = $clog2(COOLDOWN_FRAMES + 2);

  localparam logic [11:0] X_OFF =
    12'((PLAYER_WIDTH - PROJECTILE_WIDTH) / 2);
  localparam logic [11:0] Y_LAUNCH = 12'(LAUNCH_Y);
  localparam logic [11:0] Y_STEP   = 12'(SPEED);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } state_t;

  state_t      state_q, state_d;
  logic        fire_q, fire_d;
  logic        pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic        act_q, act_d;
  logic        shot_q, shot_d;
  logic        rise;

  assign rise = fire & ~fire_q;

  always_comb begin
    state_d = state_q;
    fire_d  = fire;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    act_d   = act_q;
    shot_d  = 1'b0;
    if (!game_active) begin
      state_d = IDLE;
      act_d   = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick && pend_q) begin
            state_d = FLYING;
            xpos_d  = player_xpos + X_OFF;
            ypos_d  = Y_LAUNCH;
            act_d   = 1'b1;
            shot_d  = 1'b1;
            pend_d  = 1'b0;
          end else if (rise) begin
            pend_d = 1'b1;
          end
        end
        FLYING: begin
          // A hit wins over a same-cycle tick so the hit position sticks
          if (bullet_hit) begin
            state_d = COOLDOWN;
            act_d   = 1'b0;
            cnt_d   = CD_LOAD;
          end else if (tick) begin
            if (ypos_q < Y_STEP) begin
              state_d = COOLDOWN;
              act_d   = 1'b0;
              cnt_d   = CD_LOAD;
            end else begin
              ypos_d = ypos_q - Y_STEP;
            end
          end
        end
        COOLDOWN: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else if (tick) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fire_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      act_q   <= 1'b0;
      shot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fire_q  <= fire_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      act_q   <= act_d;
      shot_q  <= shot_d;
    end
  end

  assign projectile_xpos = xpos_q;
  assign projectile_ypos = ypos_q;
  assign bullet_active   = act_q;
  assign shot_fired      = shot_q;

endmodule

// File: tb/tb_projectile_ctl.sv
// Bench for projectile_ctl: reference model feeds a scoreboard queue,
// a monitor pops and compares after every clock edge.
module tb_projectile_ctl;

  localparam int X_OFF  = 24;
  localparam int LY     = 668;
  localparam int SPD    = 8;
  localparam int CD     = 15;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        fire;
  logic        game_active;
  logic [11:0] player_xpos;
  logic        bullet_hit;
  logic [11:0] projectile_xpos;
  logic [11:0] projectile_ypos;
  logic        bullet_active;
  logic        shot_fired;

  projectile_ctl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .fire            (fire),
    .game_active     (game_active),
    .player_xpos     (player_xpos),
    .bullet_hit      (bullet_hit),
    .projectile_xpos (projectile_xpos),
    .projectile_ypos (projectile_ypos),
    .bullet_active   (bullet_active),
    .shot_fired      (shot_fired)
  );

  typedef struct {
    int x;
    int y;
    int act;
    int shot;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: a shot is either in the air, cooling with a number
  // of frames left, or neither (ready).
  bit m_flying = 0;
  int m_cool   = -1;
  bit m_pend   = 0;
  bit m_prev   = 0;
  int m_x = 0, m_y = 0, m_act = 0, m_shot = 0;

  always @(posedge clk) begin : model
    bit   rise;
    exp_t e;
    rise = fire && !m_prev;
    if (!rst_n) begin
      m_flying = 0; m_cool = -1; m_pend = 0; m_prev = 0;
      m_x = 0; m_y = 0; m_act = 0; m_shot = 0;
    end else begin
      m_shot = 0;
      if (!game_active) begin
        m_flying = 0; m_cool = -1; m_pend = 0; m_act = 0;
      end else if (m_flying) begin
        if (bullet_hit) begin
          m_flying = 0; m_act = 0; m_cool = CD;
        end else if (tick) begin
          if (m_y < SPD) begin
            m_flying = 0; m_act = 0; m_cool = CD;
          end else begin
            m_y = m_y - SPD;
          end
        end
      end else if (m_cool >= 0) begin
        if (m_cool == 0) m_cool = -1;
        else if (tick) begin
          m_cool = m_cool - 1;
          if (m_cool == 0) m_cool = -1;
        end
      end else begin
        if (tick && m_pend) begin
          m_flying = 1; m_pend = 0;
          m_x = (int'(player_xpos) + X_OFF) % 4096;
          m_y = LY; m_act = 1; m_shot = 1;
        end else if (rise) begin
          m_pend = 1;
        end
      end
      m_prev = fire;
    end
    e = '{m_x, m_y, m_act, m_shot};
    sb_q.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      pops++;
      chk("sb_xpos", int'(projectile_xpos), e.x);
      chk("sb_ypos", int'(projectile_ypos), e.y);
      chk("sb_active", int'(bullet_active), e.act);
      chk("sb_shot", int'(shot_fired), e.shot);
    end
  end

  task automatic cyc(input logic t, input logic f, input logic h);
    @(negedge clk);
    tick = t;
    fire = f;
    bullet_hit = h;
    @(posedge clk);
    #2;
  endtask

  task automatic launch();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 1'b0;
    fire = 1'b0;
    bullet_hit = 1'b0;
    game_active = 1'b1;
    player_xpos = 12'd400;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("rst_xpos", int'(projectile_xpos), 0);
    chk("rst_ypos", int'(projectile_ypos), 0);
    chk("rst_active", int'(bullet_active), 0);
    chk("rst_shot", int'(shot_fired), 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    launch();
    chk("launch_shot", int'(shot_fired), 1);
    chk("launch_xpos", int'(projectile_xpos), 424);
    chk("launch_ypos", int'(projectile_ypos), 668);
    chk("launch_active", int'(bullet_active), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("shot_one_cycle", int'(shot_fired), 0);

    player_xpos = 12'd100;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("flight_ypos", int'(projectile_ypos), 644);
    chk("flight_xpos_held", int'(projectile_xpos), 424);

    repeat (43) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_hit_ypos", int'(projectile_ypos), 300);
    cyc(1'b1, 1'b0, 1'b1);
    chk("hit_active", int'(bullet_active), 0);
    chk("hit_ypos", int'(projectile_ypos), 300);

    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
    chk("cool_active", int'(bullet_active), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("cool_no_queue", int'(shot_fired), 0);
    launch();
    chk("refire_shot", int'(shot_fired), 1);
    chk("refire_xpos", int'(projectile_xpos), 124);

    repeat (83) cyc(1'b1, 1'b0, 1'b0);
    chk("top_ypos4", int'(projectile_ypos), 4);
    chk("top_active83", int'(bullet_active), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("top_retire", int'(bullet_active), 0);
    chk("top_no_wrap", int'(projectile_ypos), 4);

    repeat (15) cyc(1'b1, 1'b0, 1'b0);
    launch();
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    game_active = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_active", int'(bullet_active), 0);
    game_active = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    launch();
    chk("relaunch_active", int'(bullet_active), 1);
    cyc(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("midrst_xpos", int'(projectile_xpos), 0);
    chk("midrst_ypos", int'(projectile_ypos), 0);
    chk("midrst_active", int'(bullet_active), 0);
    chk("midrst_shot", int'(shot_fired), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      tick        = ($urandom_range(0, 3) == 0);
      bullet_hit  = ($urandom_range(0, 39) == 0);
      game_active = ($urandom_range(0, 299) != 0);
      rst_n       = ($urandom_range(0, 999) != 0);
      player_xpos = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) fire = ~fire;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    chk("sb_drained", sb_q.size(), 0);
    chk("sb_active_mon", int'(pops > 6000), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/projectile_ctl.md
Name: projectile_ctl

Overview:
- Player projectile controller. Sits directly upstream of the invader collision stage.
- Launches one projectile from the player cannon on a fire press and advances it upward once per frame tick.
- Drives the projectile position and the active flag consumed by the collision stage.
- Retires the projectile on a hit pulse from the collision stage or on reaching the screen top, then enforces a re-fire cooldown.

Parameters:
PLAYER_WIDTH, 64, player sprite width in pixels
PROJECTILE_WIDTH, 16, projectile sprite width in pixels
LAUNCH_Y, 668, projectile ypos at launch (top edge of player)
SPEED, 8, pixels moved up per frame tick
COOLDOWN_FRAMES, 15, frame ticks in COOLDOWN before re-fire is allowed

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
tick  in  1  one-cycle pulse once per video frame
fire  in  1  debounced fire button, level
game_active  in  1  high while a game is running
player_xpos  in  12  left edge of player sprite
bullet_hit  in  1  one-cycle pulse from the collision stage: projectile hit an invader
projectile_xpos  out  12  projectile left edge
projectile_ypos  out  12  projectile top edge
bullet_active  out  1  projectile in flight
shot_fired  out  1  one-cycle pulse on launch (sound/score hooks)

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values: projectile_xpos=0, projectile_ypos=0, bullet_active=0, shot_fired=0, state=IDLE, fire_q=0, fire_pending=0, cooldown counter=0.
- Fire edge detect:
  - fire_q registers fire.
  - A rise is fire & ~fire_q.
  - A rise seen in IDLE with game_active=1 sets fire_pending.
  - A rise seen in any other state is discarded. There is no queuing.
- States: IDLE, FLYING, COOLDOWN.
- IDLE:
  - On a tick with fire_pending=1: go to FLYING.
  - projectile_xpos <= player_xpos + (PLAYER_WIDTH-PROJECTILE_WIDTH)/2, computed in 12 bits and truncated.
  - projectile_ypos <= LAUNCH_Y.
  - bullet_active <= 1, shot_fired <= 1 for exactly one cycle, fire_pending <= 0.
  - Latency: a rise at cycle N is eligible to launch on any tick at cycle >= N+1.
- FLYING:
  - projectile_xpos is held. It does not follow the player.
  - bullet_hit=1: go to COOLDOWN, bullet_active <= 0, position held. This takes priority over a simultaneous tick, so no move occurs that cycle.
  - Else, on a tick:
    - If projectile_ypos < SPEED: go to COOLDOWN, bullet_active <= 0. This is the top-of-screen retire and prevents unsigned wrap.
    - Otherwise projectile_ypos <= projectile_ypos - SPEED.
  - bullet_hit outside FLYING is ignored.
- COOLDOWN:
  - On entry, the counter loads COOLDOWN_FRAMES.
  - Each tick decrements the counter.
  - A tick that finds the counter at 1 goes to IDLE.
  - COOLDOWN_FRAMES=0: return to IDLE on the next cycle.
- game_active=0 in any state: next cycle state=IDLE, bullet_active=0, fire_pending=0, counter=0. Positions hold.
- Reset asserted mid-flight: all registers return to reset values on that edge. There is no residual pulse.
- bullet_active and projectile_ypos change only on clock edges. The collision stage sees a stable position for the whole frame between ticks.

Test Plan:
- Launch: player_xpos=400, one-cycle fire rise, then a tick -> shot_fired one cycle; projectile_xpos=424, projectile_ypos=668, bullet_active=1.
- Flight: after launch, 3 ticks -> projectile_ypos=644, projectile_xpos stays 424 while player_xpos changes to 100.
- Top retire: launch, then 84 ticks -> ypos reaches 4 after the 83rd tick; bullet_active falls after the 84th tick; ypos never wraps above 668.
- Hit with simultaneous tick: FLYING at ypos=300, bullet_hit and tick in the same cycle -> bullet_active=0 next cycle, ypos stays 300, state COOLDOWN.
- Cooldown: fire rises during COOLDOWN are ignored. After 15 ticks, state is IDLE. A new fire rise plus a tick relaunches, with shot_fired pulsing once.
- Abort/reset: game_active dropped mid-flight -> bullet_active=0 next cycle. rst_n=0 mid-flight -> all outputs 0 on the next edge.
